// File: rtl/noise_mixer_pkg.sv
// Shared types and helpers for the noise sound mixer: channel state, default
// envelope geometry and the decay step rule.
package noise_mixer_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, DECAY} env_state_t;

  localparam int ENV_W_DEF       = 8;
  localparam int HOLD_TICKS_DEF  = 64;
  localparam int DECAY_SHIFT_DEF = 4;

  localparam int ENV_FULL  = (1 << ENV_W_DEF) - 1;
  localparam int ENV_HALF  = (1 << (ENV_W_DEF - 1)) - 1;
  localparam int MIX_SHIFT = 16 - (ENV_W_DEF + 2);

  // Proportional decay that never stalls: small envelopes still step by one.
  function automatic int unsigned decay_step(input int unsigned env, input int unsigned shift);
    int unsigned s;
    s = env >> shift;
    return (s == 0) ? 1 : s;
  endfunction

endpackage

// File: rtl/noise_env_channel.sv
// One envelope channel: IDLE/HOLD/DECAY envelope, hold counter and noise tap
// capture, producing a signed +/-env contribution.
module noise_env_channel
  import noise_mixer_pkg::*;
#(
  parameter int ENV_W       = ENV_W_DEF,
  parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_trig,
  input  logic               i_loud,
  input  logic               i_noise,
  output logic signed [ENV_W:0] o_contrib,
  output env_state_t         o_state
);

  localparam int HC_W = $clog2(HOLD_TICKS + 1);
  localparam logic [ENV_W-1:0] L_FULL = {ENV_W{1'b1}};
  localparam logic [ENV_W-1:0] L_HALF = {1'b0, {(ENV_W-1){1'b1}}};

  env_state_t       r_state, w_state_nxt;
  logic [ENV_W-1:0] r_env, w_env_nxt, w_step;
  logic [HC_W-1:0]  r_hold, w_hold_nxt;
  logic             r_noise;

  assign w_step = ENV_W'(decay_step(32'(r_env), DECAY_SHIFT));

  // A trigger takes priority over a coincident tick; the tick is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_hold_nxt  = r_hold;
    if (i_trig) begin
      w_env_nxt   = i_loud ? L_FULL : L_HALF;
      w_hold_nxt  = HC_W'(HOLD_TICKS);
      w_state_nxt = HOLD;
    end else if (i_tick) begin
      case (r_state)
        HOLD: begin
          if (r_hold <= HC_W'(1)) begin
            w_hold_nxt  = '0;
            w_state_nxt = DECAY;
          end else begin
            w_hold_nxt = r_hold - HC_W'(1);
          end
        end
        DECAY: begin
          if (r_env <= w_step) begin
            w_env_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_env_nxt = r_env - w_step;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_env   <= '0;
      r_hold  <= '0;
      r_noise <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
      r_hold  <= w_hold_nxt;
      if (i_tick) r_noise <= i_noise;
    end
  end

  assign o_contrib = r_noise ? $signed({1'b0, r_env}) : -$signed({1'b0, r_env});
  assign o_state   = r_state;

endmodule

// File: rtl/noise_sound_mixer.sv
// Two-channel noise envelope mixer feeding a valid/ready PCM sample stream.
// Define NOISE_MIXER_LPF_EN to insert a one-pole low-pass before the output.
module noise_sound_mixer
  import noise_mixer_pkg::*;
#(
  parameter int ENV_W       = ENV_W_DEF,
  parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_6KHz_en,
  input  logic               noise_a,
  input  logic               noise_b,
  input  logic               trig_a,
  input  logic               trig_b,
  input  logic               loud,
  input  logic               mute,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               active
);

  localparam int L_MIX_SHIFT = 16 - (ENV_W + 2);

  logic signed [ENV_W:0]   w_ca, w_cb;
  env_state_t              w_sa, w_sb;
  logic signed [ENV_W+1:0] w_sum;
  logic signed [15:0]      w_mix, w_filt, w_out;
  logic signed [15:0]      r_sample;
  logic                    r_valid, r_ovr, r_load;

  noise_env_channel #(.ENV_W(ENV_W), .HOLD_TICKS(HOLD_TICKS), .DECAY_SHIFT(DECAY_SHIFT)) u_chan_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(clk_6KHz_en), .i_trig(trig_a),
    .i_loud(loud), .i_noise(noise_a), .o_contrib(w_ca), .o_state(w_sa)
  );

  noise_env_channel #(.ENV_W(ENV_W), .HOLD_TICKS(HOLD_TICKS), .DECAY_SHIFT(DECAY_SHIFT)) u_chan_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(clk_6KHz_en), .i_trig(trig_b),
    .i_loud(loud), .i_noise(noise_b), .o_contrib(w_cb), .o_state(w_sb)
  );

  // Two +/-(2^ENV_W-1) terms fit in ENV_W+2 bits, so no saturation.
  assign w_sum = $signed({w_ca[ENV_W], w_ca}) + $signed({w_cb[ENV_W], w_cb});
  assign w_mix = {w_sum, {L_MIX_SHIFT{1'b0}}};

`ifdef NOISE_MIXER_LPF_EN
  logic signed [19:0] r_acc, w_acc_nxt;

  assign w_acc_nxt = r_acc + 20'(w_mix) - (r_acc >>> 3);
  assign w_filt    = w_acc_nxt[18:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_acc <= '0;
    else if (r_load) r_acc <= w_acc_nxt;
  end
`else
  assign w_filt = w_mix;
`endif

  assign w_out = mute ? 16'sd0 : w_filt;

  // Load lands one cycle after the tick so it sees the post-tick envelope.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load   <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_load <= clk_6KHz_en;
      if (r_load) begin
        r_sample <= w_out;
        r_valid  <= 1'b1;
        if (r_valid && !sample_ready) r_ovr <= 1'b1;
      end else if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_ovr;
  assign active       = (w_sa != IDLE) || (w_sb != IDLE);

endmodule

// File: tb/tb_noise_sound_mixer.sv
// Randomized and directed bench for noise_sound_mixer against an arithmetic
// reference model of envelopes, mix, optional low-pass and stream handshake.
module tb_noise_sound_mixer;

  logic clk = 1'b0, rst_n = 1'b0, clk_6KHz_en = 1'b0;
  logic noise_a = 1'b0, noise_b = 1'b0, trig_a = 1'b0, trig_b = 1'b0;
  logic loud = 1'b0, mute = 1'b0, sample_ready = 1'b1;
  logic [15:0] sample_out;
  logic sample_valid, overrun, active;

  int n_chk = 0, n_fail = 0;

  // Reference model state: phase 0 idle, 1 hold, 2 decay.
  int   m_env[2], m_hold[2], m_ph[2];
  bit   m_nz[2];
  int   m_acc;
  logic [15:0] m_out;
  bit   m_valid, m_ovr, m_load;

  noise_sound_mixer dut (
    .clk(clk), .rst_n(rst_n), .clk_6KHz_en(clk_6KHz_en),
    .noise_a(noise_a), .noise_b(noise_b), .trig_a(trig_a), .trig_b(trig_b),
    .loud(loud), .mute(mute), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_env[c] = 0; m_hold[c] = 0; m_ph[c] = 0; m_nz[c] = 0;
    end
    m_acc = 0; m_out = '0; m_valid = 0; m_ovr = 0; m_load = 0;
  endtask

  task automatic model_chan(input int c, input bit trig, input bit nz);
    int stp;
    if (trig) begin
      m_env[c] = loud ? 255 : 127; m_hold[c] = 64; m_ph[c] = 1;
    end else if (clk_6KHz_en) begin
      if (m_ph[c] == 1) begin
        m_hold[c]--;
        if (m_hold[c] == 0) m_ph[c] = 2;
      end else if (m_ph[c] == 2) begin
        stp = m_env[c] / 16;
        if (stp < 1) stp = 1;
        m_env[c] -= stp;
        if (m_env[c] <= 0) begin m_env[c] = 0; m_ph[c] = 0; end
      end
    end
    if (clk_6KHz_en) m_nz[c] = nz;
  endtask

  task automatic model_edge();
    int a, b, s;
    if (m_load) begin
      a = m_nz[0] ? m_env[0] : -m_env[0];
      b = m_nz[1] ? m_env[1] : -m_env[1];
      s = (a + b) * 64;
`ifdef NOISE_MIXER_LPF_EN
      m_acc = m_acc + s - (m_acc >>> 3);
      s = m_acc >>> 3;
`endif
      if (mute) s = 0;
      if (m_valid && !sample_ready) m_ovr = 1;
      m_out = s[15:0];
      m_valid = 1;
    end else if (m_valid && sample_ready) begin
      m_valid = 0;
    end
    model_chan(0, trig_a, noise_a);
    model_chan(1, trig_b, noise_b);
    m_load = clk_6KHz_en;
  endtask

  task automatic check_all();
    chk("sample_out", 32'(sample_out), 32'(m_out));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("active", 32'(active), 32'((m_ph[0] != 0) || (m_ph[1] != 0)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic tick1();
    clk_6KHz_en = 1'b1; step();
    clk_6KHz_en = 1'b0; step();
  endtask

  task automatic trigger(input bit a, input bit b);
    trig_a = a; trig_b = b; step();
    trig_a = 1'b0; trig_b = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    #3;
    chk("rst_sample", 32'(sample_out), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Idle stream: ten zero samples.
    for (int i = 0; i < 10; i++) begin
      tick1();
      chk("idle_sample", 32'(sample_out), 32'h0);
    end

    // Channel A loud, hold then decay to idle.
    loud = 1'b1; noise_a = 1'b1; noise_b = 1'b0;
    trigger(1, 0);
    tick1();
`ifdef NOISE_MIXER_LPF_EN
    chk("lpf_first", 32'(sample_out), 32'h07F8);
`else
    chk("a_first", 32'(sample_out), 32'h3FC0);
`endif
    repeat (63) tick1();
    tick1();
`ifndef NOISE_MIXER_LPF_EN
    chk("a_decay1", 32'(sample_out), 32'h3C00);
`endif
    n = 0;
    while (active && n < 300) begin tick1(); n++; end
    chk("a_idle", 32'(active), 32'h0);

    // Both channels, full negative then full positive.
    noise_a = 1'b0; noise_b = 1'b0;
    trigger(1, 1);
    tick1();
`ifndef NOISE_MIXER_LPF_EN
    chk("both_neg", 32'(sample_out), 32'h8080);
`endif
    noise_a = 1'b1; noise_b = 1'b1;
    tick1();
`ifndef NOISE_MIXER_LPF_EN
    chk("both_pos", 32'(sample_out), 32'h7F80);
`endif

    // Small-envelope floor: from env 10, exactly 10 decay ticks to idle.
    n = 0;
    while (!(m_ph[0] == 2 && m_env[0] == 10) && n < 400) begin tick1(); n++; end
    n = 0;
    while (active && n < 30) begin tick1(); n++; end
    chk("floor_ticks", 32'(n), 32'd10);

    // Backpressure across two ticks.
    chk("ovr_pre", 32'(overrun), 32'h0);
    noise_a = 1'b1; noise_b = 1'b0;
    trigger(1, 0);
    sample_ready = 1'b0;
    tick1();
    repeat (3) step();
    noise_a = 1'b0;
    tick1();
    chk("ovr_set", 32'(overrun), 32'h1);
`ifndef NOISE_MIXER_LPF_EN
    chk("replaced", 32'(sample_out), 32'hC040);
`endif
    step();
    sample_ready = 1'b1;
    step();
    chk("valid_drop", 32'(sample_valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Retrigger mid-decay at half level, coincident with a tick.
    noise_a = 1'b1;
    n = 0;
    while (!(m_ph[0] == 2 && m_env[0] <= 100) && n < 200) begin tick1(); n++; end
    loud = 1'b0; trig_a = 1'b1; clk_6KHz_en = 1'b1; step();
    trig_a = 1'b0; clk_6KHz_en = 1'b0; step();
`ifndef NOISE_MIXER_LPF_EN
    chk("retrig", 32'(sample_out), 32'h1FC0);
`endif
    repeat (64) tick1();
`ifndef NOISE_MIXER_LPF_EN
    chk("retrig_hold", 32'(sample_out), 32'h1FC0);
`endif
    tick1();
`ifndef NOISE_MIXER_LPF_EN
    chk("retrig_decay", 32'(sample_out), 32'h1E00);
`endif

    // Mute zeroes samples while envelopes run on.
    mute = 1'b1;
    tick1();
    chk("mute", 32'(sample_out), 32'h0);
    chk("mute_active", 32'(active), 32'h1);
    mute = 1'b0;

    // Reset mid-envelope.
    loud = 1'b1;
    trigger(1, 1);
    repeat (3) tick1();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_sample", 32'(sample_out), 32'h0);
    chk("mid_rst_valid", 32'(sample_valid), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    chk("mid_rst_active", 32'(active), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      clk_6KHz_en  = ($urandom_range(3) == 0);
      trig_a       = ($urandom_range(63) == 0);
      trig_b       = ($urandom_range(63) == 0);
      loud         = 1'($urandom_range(1));
      mute         = ($urandom_range(7) == 0);
      noise_a      = 1'($urandom_range(1));
      noise_b      = 1'($urandom_range(1));
      sample_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
